// File: rtl/exp_lut_phase_sequencer.sv
// exp_lut_phase_sequencer
// Generates the per-sample phase address into the shared 1024-entry
// exp(-i*2*pi*k/1024) LUT for FAM down-conversion after the channelizer FFT.
// The m*p*L*1024/Np product is built incrementally: a per-block step register
// (step = p*inc) and a per-sample phase accumulator (phase = m*step).
module exp_lut_phase_sequencer #(
  parameter int P       = 1024,
  parameter int NB_ADDR = 10,
  parameter int NB_P    = $clog2(P)
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [2:0]         i_NFFT_sel,
  input  logic [2:0]         i_L_sel,
  input  logic [NB_P-1:0]    i_num_blocks,
  input  logic               i_s_tvalid,
  input  logic               i_s_tlast,
  output logic               o_s_tready,
  output logic               o_m_tvalid,
  input  logic               i_m_tready,
  output logic [NB_ADDR-1:0] o_lut_addr,
  output logic [9:0]         o_m_index,
  output logic [NB_P-1:0]    o_p_index,
  output logic               o_m_tlast,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cfg_err,
  output logic               o_sync_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [9:0]         np_m1;       // latched Np-1
  logic [NB_P-1:0]    num_blocks;  // latched blocks-per-frame minus 1
  logic [NB_ADDR-1:0] inc;         // L*1024/Np mod 1024
  logic [9:0]         m;
  logic [NB_P-1:0]    p;
  logic [NB_ADDR-1:0] phase;       // m*step mod 1024
  logic [NB_ADDR-1:0] step;        // p*inc mod 1024

  logic               cfg_ok;
  logic [4:0]         inc_exp;
  logic [NB_ADDR-1:0] inc_nxt;
  logic [10:0]        np_full;
  logic [9:0]         np_m1_nxt;
  logic               accept;
  logic               hshake;
  logic               m_wrap;
  logic               frame_last;

  assign cfg_ok     = (i_NFFT_sel <= 3'd6) && (i_L_sel <= 3'd6);
  // L*1024/Np = 2^(8 + L_sel - NFFT_sel); exponent is never negative for legal selects
  assign inc_exp    = 5'd8 + {2'b00, i_L_sel} - {2'b00, i_NFFT_sel};
  assign inc_nxt    = (inc_exp < 5'd10) ? NB_ADDR'(NB_ADDR'(1) << inc_exp) : '0;
  // Np = 1024 overflows 10 bits, so compute in 11 bits and keep Np-1
  assign np_full    = 11'd16 << i_NFFT_sel;
  assign np_m1_nxt  = 10'(np_full - 11'd1);

  assign o_s_tready = (state == RUN) && (!o_m_tvalid || i_m_tready);
  assign accept     = i_s_tvalid && o_s_tready;
  assign hshake     = o_m_tvalid && i_m_tready;
  assign m_wrap     = (m == np_m1);
  assign frame_last = m_wrap && (p == num_blocks);

  // State register
  always_ff @(posedge clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE:  if (i_start && cfg_ok) state_nxt = RUN;
      RUN: begin
        o_busy = 1'b1;
        if (accept && frame_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        o_busy = 1'b1;
        if (hshake) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration latch, m/p counters, phase accumulator and output register
  always_ff @(posedge clock) begin
    if (i_reset) begin
      np_m1      <= '0;
      num_blocks <= '0;
      inc        <= '0;
      m          <= '0;
      p          <= '0;
      phase      <= '0;
      step       <= '0;
      o_m_tvalid <= 1'b0;
      o_lut_addr <= '0;
      o_m_index  <= '0;
      o_p_index  <= '0;
      o_m_tlast  <= 1'b0;
      o_cfg_err  <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      if (state == IDLE && i_start) begin
        if (cfg_ok) begin
          np_m1      <= np_m1_nxt;
          num_blocks <= i_num_blocks;
          inc        <= inc_nxt;
          m          <= '0;
          p          <= '0;
          phase      <= '0;
          step       <= '0;
        end else begin
          o_cfg_err  <= 1'b1;
        end
      end

      if (accept) begin
        o_lut_addr <= phase;
        o_m_index  <= m;
        o_p_index  <= p;
        o_m_tlast  <= frame_last;
        o_m_tvalid <= 1'b1;
        // the internal count stays authoritative; a tlast mismatch is only flagged
        if (i_s_tlast != m_wrap) o_sync_err <= 1'b1;
        if (m_wrap) begin
          m     <= '0;
          phase <= '0;
          if (!frame_last) begin
            step <= step + inc;
            p    <= p + 1'b1;
          end
        end else begin
          m     <= m + 1'b1;
          phase <= phase + step;
        end
      end else if (hshake) begin
        o_m_tvalid <= 1'b0;
      end
    end
  end

endmodule
